// File: rtl/pipe_controller.sv
// pipe_controller: step/stall sequencer for the fetch->execute->memory pipe with retire/stall statistics.
// Optional debug halt/single-step support is enabled by defining PIPE_CONTROLLER_DEBUG_EN.
module pipe_controller #(
  parameter int STALL_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         fetchReady,
  input  logic                         executeBusy,
  input  logic                         memoryBusy,
  input  logic                         hazard,
  input  logic                         jumpTaken,
`ifdef PIPE_CONTROLLER_DEBUG_EN
  input  logic                         debugHalt,
  input  logic                         debugStep,
  output logic                         halted,
`endif
  output logic                         fetchRequest,
  output logic                         fetchStep,
  output logic                         fetchStall,
  output logic                         executeStep,
  output logic                         executeStall,
  output logic                         memoryStep,
  output logic                         memoryStall,
  output logic                         retired,
  output logic [STALL_COUNT_WIDTH-1:0] stallCycles
);
  typedef enum logic [1:0] {
    IDLE,
`ifdef PIPE_CONTROLLER_DEBUG_EN
    HALT,
`endif
    RUN
  } state_t;
  state_t state, state_n;
  logic v0, v1, v2, active, freeze, bubble, flush;
`ifdef PIPE_CONTROLLER_DEBUG_EN
  logic step_q;
  // a halted pipe evaluates exactly one normal cycle on each rising edge of debugStep
  assign active = state == RUN || (state == HALT && debugStep && !step_q);
  always_comb
    state_n = state == IDLE ? (enable ? RUN : IDLE) :
              state == RUN  ? (!enable ? IDLE : debugHalt ? HALT : RUN) :
                              (debugHalt ? HALT : enable ? RUN : IDLE);
`else
  assign active = state == RUN;
  always_comb state_n = enable ? RUN : IDLE;
`endif
  always_comb begin
    freeze       = active && v2 && memoryBusy;
    bubble       = active && !freeze && v1 && (hazard || executeBusy);
    flush        = active && !freeze && !bubble && v1 && jumpTaken;
    fetchRequest = active && !freeze && !bubble && !flush;
    memoryStep   = active && !freeze;
    executeStep  = fetchRequest || flush;
    fetchStep    = fetchRequest || flush;
    memoryStall  = !((fetchRequest && v1) || flush);
    executeStall = !(fetchRequest && v0);
    fetchStall   = !(fetchRequest && fetchReady);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      v0          <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      retired     <= 1'b0;
      stallCycles <= '0;
`ifdef PIPE_CONTROLLER_DEBUG_EN
      halted      <= 1'b0;
      step_q      <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (fetchStep) v0 <= !fetchStall;
      if (executeStep) v1 <= !executeStall;
      if (memoryStep) v2 <= !memoryStall;
      retired <= memoryStep && v2;
      if ((freeze || bubble) && !(&stallCycles)) stallCycles <= stallCycles + STALL_COUNT_WIDTH'(1);
`ifdef PIPE_CONTROLLER_DEBUG_EN
      halted <= state_n == HALT;
      step_q <= debugStep;
`endif
    end
  end
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed scenarios plus random stimulus against a shift-register model of the pipe.
module tb_pipe_controller;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic enable = 0, fetchReady = 0, executeBusy = 0, memoryBusy = 0, hazard = 0, jumpTaken = 0;
  logic fetchRequest, fetchStep, fetchStall, executeStep, executeStall, memoryStep, memoryStall, retired;
  logic [W-1:0] stallCycles;
  int total = 0, bad = 0;
  logic m_run = 0, m_ret = 0;
  logic [2:0] mv = 3'b000;
  int m_cnt = 0;
  pipe_controller #(.STALL_COUNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fetchReady(fetchReady), .executeBusy(executeBusy),
    .memoryBusy(memoryBusy), .hazard(hazard), .jumpTaken(jumpTaken), .fetchRequest(fetchRequest),
    .fetchStep(fetchStep), .fetchStall(fetchStall), .executeStep(executeStep),
    .executeStall(executeStall), .memoryStep(memoryStep), .memoryStall(memoryStall),
    .retired(retired), .stallCycles(stallCycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // 0 parked, 2 freeze, 3 bubble, 4 flush, 5 advance
  function automatic int mode();
    if (!m_run) return 0;
    if (mv[2] && memoryBusy) return 2;
    if (mv[1] && (hazard || executeBusy)) return 3;
    if (mv[1] && jumpTaken) return 4;
    return 5;
  endfunction
  // model: valids as a shift register {mem,exe,fetch}
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run <= 0; mv <= 3'b000; m_ret <= 0; m_cnt <= 0;
    end else begin
      int md;
      md = mode();
      m_ret <= md >= 3 && mv[2];
      if ((md == 2 || md == 3) && m_cnt < (1 << W) - 1) m_cnt <= m_cnt + 1;
      if (md == 3) mv <= {1'b0, mv[1:0]};
      else if (md == 4) mv <= 3'b100;
      else if (md == 5) mv <= {mv[1], mv[0], fetchReady};
      m_run <= enable;
    end
  end
  always @(negedge clk) begin
    int md;
    logic [2:0] es, est;
    md = mode();
    es  = (md == 4 || md == 5) ? 3'b111 : md == 3 ? 3'b100 : 3'b000;
    est = md == 4 ? 3'b011 : md == 5 ? {!mv[1], !mv[0], !fetchReady} : 3'b111;
    chk("memoryStep", memoryStep, es[2]);
    chk("executeStep", executeStep, es[1]);
    chk("fetchStep", fetchStep, es[0]);
    if (es[2] || md == 0) chk("memoryStall", memoryStall, est[2]);
    if (es[1] || md == 0) chk("executeStall", executeStall, est[1]);
    if (es[0] || md == 0) chk("fetchStall", fetchStall, est[0]);
    chk("fetchRequest", fetchRequest, md == 5);
    chk("retired", retired, m_ret);
    chk("stallCycles", stallCycles, m_cnt);
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rand_run(input int n);
    repeat (n) begin
      enable      = $urandom_range(0, 15) != 0;
      fetchReady  = $urandom_range(0, 3) != 0;
      memoryBusy  = $urandom_range(0, 4) == 0;
      hazard      = $urandom_range(0, 6) == 0;
      executeBusy = $urandom_range(0, 9) == 0;
      jumpTaken   = $urandom_range(0, 6) == 0;
      cycles(1);
    end
    {memoryBusy, hazard, executeBusy, jumpTaken} = '0;
    enable = 1;
  endtask
  initial begin
    cycles(2);
    chk("rst_stall", stallCycles, 0);
    chk("rst_fstall", fetchStall, 1);
    rst = 1; enable = 1; fetchReady = 1;
    cycles(4);
    chk("fill_valid", mv, 3'b111);
    cycles(1);
    chk("fill_retire", retired, 1);
    memoryBusy = 1;
    cycles(4);
    memoryBusy = 0;
    chk("busy_cnt", stallCycles, 4);
    chk("busy_noret", retired, 0);
    hazard = 1;
    @(negedge clk);
    chk("haz_mstep", memoryStep, 1);
    chk("haz_mstall", memoryStall, 1);
    chk("haz_fstep", fetchStep, 0);
    chk("haz_estep", executeStep, 0);
    cycles(1);
    hazard = 0;
    chk("haz_cnt", stallCycles, 5);
    chk("haz_valid", mv, 3'b011);
    cycles(1);
    jumpTaken = 1;
    @(negedge clk);
    chk("jmp_steps", {memoryStep, executeStep, fetchStep}, 3'b111);
    chk("jmp_stalls", {memoryStall, executeStall, fetchStall}, 3'b011);
    cycles(1);
    jumpTaken = 0;
    chk("jmp_valid", mv, 3'b100);
    cycles(3);
    hazard = 1; jumpTaken = 1;
    @(negedge clk);
    chk("pri_mstep", memoryStep, 1);
    chk("pri_mstall", memoryStall, 1);
    chk("pri_fstep", fetchStep, 0);
    cycles(1);
    hazard = 0; jumpTaken = 0;
    chk("pri_valid", mv, 3'b011);
    chk("pri_cnt", stallCycles, 6);
    cycles(1);
    memoryBusy = 1;
    cycles(12);
    memoryBusy = 0;
    chk("sat_cnt", stallCycles, 4'hf);
    enable = 0;
    cycles(3);
    enable = 1;
    rand_run(400);
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("midrst_cnt", stallCycles, 0);
    chk("midrst_steps", {memoryStep, executeStep, fetchStep}, 3'b000);
    chk("midrst_stalls", {memoryStall, executeStall, fetchStall}, 3'b111);
    chk("midrst_req", fetchRequest, 0);
    cycles(1);
    rst = 1;
    rand_run(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
